// File: rtl/char_uart_tx.sv
// char_uart_tx: buffered 8N1 UART transmitter for character strings.
//
// Bytes from the upstream valid/ready stream are queued in a small FIFO
// together with their end-of-string marker. A transmit FSM pops one entry at
// a time and serialises it as start bit, 8 data bits LSB first, optional even
// parity bit, and stop bit. Every bit lasts CLKS_PER_BIT clocks.
//
// Optional feature: define CHAR_UART_TX_PARITY_EN to insert an even-parity
// bit after the data bits, which gives 11-bit frames. Without the macro,
// frames are 10 bits and there is no parity state.
//
// Parameters
//   CLKS_PER_BIT  clocks per UART bit (2..65535)
//   FIFO_DEPTH    input buffer entries (power of two, >= 2)
//
// Ports
//   clk       clock; all state changes on the rising edge
//   reset     asynchronous, active-low reset
//   in_valid  upstream byte present
//   in_data   character byte
//   in_last   byte is the final character of a string
//   in_ready  buffer can accept a byte this cycle (FIFO not full)
//   tx        serial line, idle high, registered
//   busy      FIFO non-empty or frame in progress
//   done      sticky: last-marked character fully transmitted; cleared by
//             the next accepted byte or by reset
module char_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

`ifdef CHAR_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  // ---------------------------------------------------------------------
  // Input FIFO: entries are {last, data}
  // ---------------------------------------------------------------------
  logic [8:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [8:0]       head;

  assign fifo_empty = (count_q == '0);
  assign in_ready   = (count_q != CNT_FULL);
  assign push       = in_valid && in_ready;
  assign head       = mem_q[rd_ptr_q];

  // Storage has no reset: contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_last, in_data};
    end
  end

  always_comb begin
    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;  // idle, or push and pop cancel out
    endcase
  end

  // ---------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              last_q, last_d;
  logic              end_last_q, end_last_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              baud_end;
`ifdef CHAR_UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    last_d     = last_q;
    end_last_d = 1'b0;
    pop        = 1'b0;
`ifdef CHAR_UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_d  = head[7:0];
          last_d   = head[8];
          baud_d   = '0;
          bit_d    = '0;
          state_d  = ST_START;
`ifdef CHAR_UART_TX_PARITY_EN
          parity_d = ^head[7:0];
`endif
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef CHAR_UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef CHAR_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (baud_end) begin
          baud_d     = '0;
          end_last_d = last_q;
          state_d    = ST_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // tx is a registered decode of the current state, so the line trails the
  // FSM by exactly one clock. That gives the two-cycle accept-to-start
  // latency, and the single IDLE cycle between frames shows up as one extra
  // high bit time on the line.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
`ifdef CHAR_UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // end_last_q trails the FSM by one clock like tx, so done rises on the
  // edge where the stop bit on the line actually ends.
  always_comb begin
    done_d = done_q;
    if (push) begin
      done_d = 1'b0;
    end else if (end_last_q) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      end_last_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
`ifdef CHAR_UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      end_last_q <= end_last_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
`ifdef CHAR_UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign done = done_q;
  assign busy = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: doc/char_uart_tx.md
CHAR_UART_TX -- requirements
Module: char_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries in the input buffer (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream character byte present.
REQ-006 SHALL have port in_data  input  8  character byte (ASCII).
REQ-007 SHALL have port in_last  input  1  marks the byte as the final character of a string.
REQ-008 SHALL have port in_ready  output  1  block can accept a byte this cycle.
REQ-009 SHALL have port tx  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  FIFO non-empty or frame in progress.
REQ-011 SHALL have port done  output  1  sticky; last-marked character fully transmitted.

Function
REQ-012 SHALL accept a byte when in_valid and in_ready are both high at a rising edge, storing {in_last, in_data} in the FIFO.
REQ-013 SHALL drive in_ready = not FIFO full, combinationally from registered state; in_valid while full SHALL be ignored with no data loss or corruption.
REQ-014 SHALL implement a transmit FSM with states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-015 IDLE with FIFO non-empty SHALL pop the head entry in that cycle and enter START on the next edge; tx SHALL be registered.
REQ-016 START SHALL hold tx=0 for CLKS_PER_BIT cycles.
REQ-017 DATA SHALL send 8 bits LSB first, each held CLKS_PER_BIT cycles.
REQ-018 STOP SHALL hold tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-019 Back-to-back frames SHALL be separated by exactly one IDLE cycle with tx=1.
REQ-020 Latency SHALL be exactly 2 cycles from the accepting edge into an empty, idle block to tx first low.
REQ-021 A simultaneous FIFO push and pop in one cycle SHALL both take effect, leaving the count unchanged.
REQ-022 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 The bit counter SHALL be 3 bits; the baud counter SHALL be wide enough for CLKS_PER_BIT-1.
REQ-024 done SHALL set on the edge ending the STOP bit of a frame whose in_last was 1, and remain set.
REQ-025 done SHALL clear on the next accepted byte, or on reset.
REQ-026 busy SHALL be high whenever the FSM is not in IDLE or the FIFO is non-empty.

Reset
REQ-027 Reset low SHALL immediately force the FSM to IDLE, empty the FIFO, and clear all counters.
REQ-028 Reset SHALL drive tx=1, in_ready=1, busy=0, done=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with tx high immediately and discard all buffered bytes.
REQ-030 After reset release, the first active edge SHALL behave as a normal IDLE cycle.

Configuration
REQ-031 Macro CHAR_UART_TX_PARITY_EN defined: the PARITY state SHALL follow DATA and send an even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving an 11-bit frame.
REQ-032 Macro CHAR_UART_TX_PARITY_EN undefined: there SHALL be no PARITY state and frames SHALL be 10 bits.

Verification
REQ-033 Single 'H' (0x48), CLKS_PER_BIT=4, no parity: tx low 2 cycles after accept; bits 0,0,0,1,0,0,1,0 at 4 cycles each; stop high; frame lasts 40 cycles.
REQ-034 Stream "Hello, World!" with in_last on '!' (0x21) and in_valid held high: in_ready toggles on FIFO full; all 13 bytes appear in order; 1 idle cycle between frames; done rises after the 13th stop bit ends.
REQ-035 Fill the FIFO (4 bytes) while the first frame is still in START: in_ready=0; a 5th byte is held and accepted after the first pop; no byte lost or duplicated.
REQ-036 Assert reset during the DATA bit 3 of 'e' (0x65): tx=1 immediately; busy=0, done=0, in_ready=1; the next byte transmits cleanly.
REQ-037 With the parity macro defined, send 'W' (0x57): parity bit=1; send 'e' (0x65): parity bit=0; each frame lasts 44 cycles.
REQ-038 Push on the same edge the FIFO pops (count 1): count stays 1 and the byte order is preserved.
